// File: rtl/mult_div_ctrl.sv
// E-stage multiply/divide sequencer and HI/LO register owner.
// Results are computed at issue and committed after a fixed latency.
module mult_div_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        md_use_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   res_hi_q, res_hi_d;
  logic [31:0]   res_lo_q, res_lo_d;
  logic          res_valid_q, res_valid_d;

  logic        is_md;
  logic        sgn;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] dvs;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] quo_o;
  logic [31:0] rem_o;

  always_comb begin
    is_md  = start & (md_op <= 3'd3);
    sgn    = (md_op == 3'd2);
    prod_s = {{32{src_a[31]}}, src_a}
           * {{32{src_b[31]}}, src_b};
    prod_u = {32'd0, src_a} * {32'd0, src_b};
    mag_a  = (sgn & src_a[31]) ? (~src_a + 32'd1) : src_a;
    mag_b  = (sgn & src_b[31]) ? (~src_b + 32'd1) : src_b;
    // divisor forced nonzero; the result is discarded anyway
    dvs    = (src_b == 32'd0) ? 32'd1 : mag_b;
    quo    = mag_a / dvs;
    rem    = mag_a % dvs;
    quo_o  = (sgn & (src_a[31] ^ src_b[31]))
           ? (~quo + 32'd1) : quo;
    rem_o  = (sgn & src_a[31]) ? (~rem + 32'd1) : rem;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    res_valid_d = res_valid_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (md_op)
            3'd0: begin
              res_hi_d    = prod_s[63:32];
              res_lo_d    = prod_s[31:0];
              res_valid_d = 1'b1;
              cnt_d       = CW'(MULT_CYCLES);
              state_d     = RUN;
            end
            3'd1: begin
              res_hi_d    = prod_u[63:32];
              res_lo_d    = prod_u[31:0];
              res_valid_d = 1'b1;
              cnt_d       = CW'(MULT_CYCLES);
              state_d     = RUN;
            end
            3'd2, 3'd3: begin
              res_hi_d    = rem_o;
              res_lo_d    = quo_o;
              res_valid_d = (src_b != 32'd0);
              cnt_d       = CW'(DIV_CYCLES);
              state_d     = RUN;
            end
            3'd4: hi_d = src_a;
            3'd5: lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (res_valid_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      res_valid_q <= res_valid_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q == RUN) | is_md;
  assign stall = md_use_D & busy;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed bench for mult_div_ctrl: latency, arithmetic,
// stall window, mthi/mtlo and mid-operation reset.
module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        md_use_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        stall;

  int n_chk = 0;
  int n_err = 0;

  mult_div_ctrl #(
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .md_op   (md_op),
    .src_a   (src_a),
    .src_b   (src_b),
    .md_use_D(md_use_D),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .stall   (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic md_run(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input int n,
                        input logic [31:0] old_hi,
                        input logic [31:0] old_lo,
                        input logic [31:0] new_hi,
                        input logic [31:0] new_lo);
    for (int k = 0; k <= n; k++) begin
      if (k == 0) begin
        chk({tag, "_idle_pre"}, busy, 1'b0);
        start = 1'b1;
        md_op = op;
        src_a = a;
        src_b = b;
      end else begin
        cyc();
        start = 1'b0;
      end
      #1;
      chk({tag, "_busy"}, busy, 1'b1);
      chk({tag, "_hi_old"}, hi, old_hi);
      chk({tag, "_lo_old"}, lo, old_lo);
    end
    cyc();
    start = 1'b0;
    #1;
    chk({tag, "_busy_end"}, busy, 1'b0);
    chk({tag, "_hi"}, hi, new_hi);
    chk({tag, "_lo"}, lo, new_lo);
  endtask

  task automatic mt(input string tag,
                    input logic [2:0] op,
                    input logic [31:0] v,
                    input logic [31:0] exp_hi,
                    input logic [31:0] exp_lo);
    start = 1'b1;
    md_op = op;
    src_a = v;
    src_b = 32'd0;
    #1;
    chk({tag, "_busy"}, busy, 1'b0);
    cyc();
    start = 1'b0;
    #1;
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    md_op    = 3'd7;
    src_a    = 32'd0;
    src_b    = 32'd0;
    md_use_D = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_stall", stall, 1'b0);

    // mult -2*3 with mfhi waiting in D for the whole window
    md_use_D = 1'b1;
    for (int k = 0; k <= 5; k++) begin
      if (k == 0) begin
        start = 1'b1;
        md_op = 3'd0;
        src_a = 32'hFFFF_FFFE;
        src_b = 32'd3;
      end else begin
        cyc();
        start = 1'b0;
      end
      #1;
      chk("mult_busy", busy, 1'b1);
      chk("mult_stall", stall, 1'b1);
      chk("mult_hi_old", hi, 32'd0);
      chk("mult_lo_old", lo, 32'd0);
    end
    cyc();
    start = 1'b1;
    md_op = 3'd5;
    src_a = 32'h0000_ABCD;
    #1;
    chk("mult_stall_end", stall, 1'b0);
    chk("mtlo_busy", busy, 1'b0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);
    cyc();
    start = 1'b0;
    md_use_D = 1'b0;
    #1;
    chk("mtlo_lo", lo, 32'h0000_ABCD);
    chk("mtlo_hi", hi, 32'hFFFF_FFFF);
    chk("mtlo_busy2", busy, 1'b0);

    md_run("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5,
           32'hFFFF_FFFF, 32'h0000_ABCD,
           32'h0000_0001, 32'hFFFF_FFFE);

    md_run("div", 3'd2, 32'hFFFF_FFF9, 32'd2, 10,
           32'h0000_0001, 32'hFFFF_FFFE,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);

    mt("mthi", 3'd4, 32'h0000_1234, 32'h0000_1234, 32'hFFFF_FFFD);
    mt("mtlo", 3'd5, 32'h0000_5678, 32'h0000_1234, 32'h0000_5678);

    md_run("divu0", 3'd3, 32'h0000_0064, 32'd0, 10,
           32'h0000_1234, 32'h0000_5678,
           32'h0000_1234, 32'h0000_5678);

    md_run("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10,
           32'h0000_1234, 32'h0000_5678,
           32'h0000_0000, 32'h8000_0000);

    md_run("divu", 3'd3, 32'hFFFF_FFFF, 32'd16, 10,
           32'h0000_0000, 32'h8000_0000,
           32'h0000_000F, 32'h0FFF_FFFF);

    md_run("divneg", 3'd2, 32'd7, 32'hFFFF_FFFE, 10,
           32'h0000_000F, 32'h0FFF_FFFF,
           32'h0000_0001, 32'hFFFF_FFFD);

    // no-op codes leave everything alone
    start = 1'b1;
    md_op = 3'd6;
    src_a = 32'hDEAD_BEEF;
    md_use_D = 1'b1;
    #1;
    chk("nop_busy", busy, 1'b0);
    chk("nop_stall", stall, 1'b0);
    cyc();
    start = 1'b0;
    md_use_D = 1'b0;
    #1;
    chk("nop_hi", hi, 32'h0000_0001);
    chk("nop_lo", lo, 32'hFFFF_FFFD);

    mt("mthi2", 3'd4, 32'h0000_BEEF, 32'h0000_BEEF, 32'hFFFF_FFFD);

    // reset three cycles into a divide
    start = 1'b1;
    md_op = 3'd2;
    src_a = 32'd100;
    src_b = 32'd7;
    #1;
    chk("rdiv_busy0", busy, 1'b1);
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    #1;
    chk("rdiv_busy3", busy, 1'b1);
    cyc();
    reset = 1'b0;
    #1;
    chk("rdiv_hi", hi, 32'd0);
    chk("rdiv_lo", lo, 32'd0);
    chk("rdiv_busy", busy, 1'b0);
    for (int k = 0; k < 9; k++) begin
      cyc();
      #1;
      chk("rdiv_nocommit_hi", hi, 32'd0);
      chk("rdiv_nocommit_lo", lo, 32'd0);
      chk("rdiv_idle", busy, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
